// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   state_t   : scan FSM states
//   SEG_OFF   : segment bus value with every segment dark (active-high form)
//   DIGIT_OFF : digit enable value with every digit dark (active-high form, widest case)
//   hex7()    : nibble to {g,f,e,d,c,b,a} segment pattern, bit0 = a, active-high
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  localparam logic [6:0] SEG_OFF   = 7'h00;
  localparam logic [7:0] DIGIT_OFF = 8'h00;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit decoder.
//   nibble : 4-bit value to show
//   seg    : active-high segments {g,f,e,d,c,b,a}, bit0 = a
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS hex digits on a shared segment bus.
// A write strobe from the register slave captures the value into a staging buffer; the staging
// buffer is copied to the display buffer only at a frame boundary, so a frame never tears.
// Each digit slot is SCAN_DIV cycles: a drive phase followed by BLANK_CYCLES with all digits off.
//   clk, reset : clock, asynchronous active-high reset
//   data_in    : display value, digit k shows data_in[4k+3:4k]
//   dp_in      : decimal-point request per digit
//   data_load  : 1-cycle capture strobe into staging
//   enable     : 1 = scan, 0 = dark
//   seg_out    : segments {g,f,e,d,c,b,a}, registered
//   dp_out     : decimal point of the active digit, registered
//   digit_sel  : one-hot digit enable, registered
//   frame_tick : 1-cycle pulse on every frame commit
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           data_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  data_load,
  input  logic                  enable,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] DriveLast = CntW'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] DigOff  = DIGIT_OFF[NUM_DIGITS-1:0];
  localparam logic [6:0]            SegIdle = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] SelIdle = ACTIVE_LOW ? ~DigOff : DigOff;
  localparam logic                  DpIdle  = ACTIVE_LOW;

  state_t          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IdxW-1:0] index_q, index_d;

  logic [31:0]           stage_data_q, stage_data_d;
  logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d;
  logic [31:0]           disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic                  commit;

  logic [3:0]            nibble;
  logic [6:0]            seg_raw;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] sel_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
    end
  end

  // Next-state logic; the count restarts on every state change
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
      index_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = DRIVE;
          count_d = '0;
          index_d = '0;
        end
        DRIVE: begin
          if (count_q == DriveLast) begin
            state_d = BLANK;
            count_d = '0;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
        BLANK: begin
          if (count_q == BlankLast) begin
            state_d = DRIVE;
            count_d = '0;
            index_d = (index_q == IdxLast) ? '0 : index_q + IdxW'(1);
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          index_d = '0;
        end
      endcase
    end
  end

  // Frame boundary: entering DRIVE for digit 0 (from IDLE or on wrap from BLANK)
  assign commit = (state_d == DRIVE) && (index_d == '0) && (state_q != DRIVE);

  // Double buffer. A load coinciding with a commit lands in staging after the old
  // staging value has been handed to the display, so it stays pending.
  always_comb begin
    stage_data_d = stage_data_q;
    stage_dp_d   = stage_dp_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    if (commit && pending_q) begin
      disp_data_d = stage_data_q;
      disp_dp_d   = stage_dp_q;
      pending_d   = 1'b0;
    end
    if (data_load) begin
      stage_data_d = data_in;
      stage_dp_d   = dp_in;
      pending_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_data_q <= '0;
      stage_dp_q   <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
    end else begin
      stage_data_q <= stage_data_d;
      stage_dp_q   <= stage_dp_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
    end
  end

  assign nibble = disp_data_d[{index_d, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // Outputs are computed from the next state so the registered outputs line up with the state
  // register: segments and digit enables always change on the same edge.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    sel_d = DigOff;
    if (state_d == DRIVE) begin
      seg_d = seg_raw;
      dp_d  = disp_dp_d[index_d];
      for (int i = 0; i < NUM_DIGITS; i++) begin
        sel_d[i] = (index_d == IdxW'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out    <= SegIdle;
      dp_out     <= DpIdle;
      digit_sel  <= SelIdle;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= ACTIVE_LOW ? ~seg_d : seg_d;
      dp_out     <= ACTIVE_LOW ? ~dp_d : dp_d;
      digit_sel  <= ACTIVE_LOW ? ~sel_d : sel_d;
      frame_tick <= commit;
    end
  end

endmodule
